// File: rtl/fifo_arb_pkg.sv
// Shared types and the round-robin pick helper for the FIFO write-port arbiter.
// Sized for up to 16 requesters; callers pass their real requester count.
package fifo_arb_pkg;

    localparam int MAX_REQ   = 16;
    localparam int MAX_IDX_W = 4;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        OWN  = 1'b1
    } arb_state_t;

    typedef struct packed {
        logic                 found;
        logic [MAX_IDX_W-1:0] index;
    } pick_t;

    typedef logic [MAX_IDX_W:0] wide_idx_t;

    // Scans last_grant+1, last_grant+2, ... modulo num_req; the nearest set bit wins.
    function automatic pick_t rr_pick(
        input logic [MAX_REQ-1:0]   req,
        input logic [MAX_IDX_W-1:0] last_grant,
        input int                   num_req
    );
        pick_t     res;
        wide_idx_t idx;
        res = '0;
        for (int k = MAX_REQ; k >= 1; k--) begin
            if (k <= num_req) begin
                idx = wide_idx_t'(last_grant) + wide_idx_t'(k);
                if (idx >= wide_idx_t'(num_req)) begin
                    idx = idx - wide_idx_t'(num_req);
                end
                if (req[idx[MAX_IDX_W-1:0]]) begin
                    res.found = 1'b1;
                    res.index = idx[MAX_IDX_W-1:0];
                end
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational rotate-and-priority-encode: next requester after last_grant.
module rr_priority_picker
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IW      = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      last_grant,
    output logic               found,
    output logic [IW-1:0]      index
);

    pick_t pick_res;

    always_comb begin
        pick_res = rr_pick(MAX_REQ'(req), MAX_IDX_W'(last_grant), NUM_REQ);
        found    = pick_res.found;
        index    = pick_res.index[IW-1:0];
    end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin, burst-limited arbiter sharing one FIFO write port among NUM_REQ requesters.
// Grant, write enable and data are combinational; ownership state updates on wclk.
module fifo_write_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int DSIZE     = 8,
    parameter int NUM_REQ   = 4,
    parameter int BURST_MAX = 4
) (
    input  logic                       wclk,
    input  logic                       wrst_n,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*DSIZE-1:0]   req_data,
    output logic [NUM_REQ-1:0]         ack,
    input  logic                       full,
    output logic                       w_en,
    output logic [DSIZE-1:0]           data_in,
    output logic                       busy,
    output logic [$clog2(NUM_REQ)-1:0] owner
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int BW = $clog2(BURST_MAX + 1);

    arb_state_t      state_reg;
    logic [IW-1:0]   owner_reg;
    logic [IW-1:0]   last_grant_reg;
    logic [BW-1:0]   burst_cnt_reg;

    logic            pick_found;
    logic [IW-1:0]   pick_idx;
    logic [IW-1:0]   sel;
    logic            cont;
    logic            any_cand;
    logic            write;
    logic [DSIZE-1:0] req_words [NUM_REQ];

    rr_priority_picker #(
        .NUM_REQ (NUM_REQ),
        .IW      (IW)
    ) u_picker (
        .req        (req),
        .last_grant (last_grant_reg),
        .found      (pick_found),
        .index      (pick_idx)
    );

    assign cont     = (state_reg == OWN) && req[owner_reg] && (burst_cnt_reg < BW'(BURST_MAX));
    assign sel      = cont ? owner_reg : pick_idx;
    assign any_cand = cont || pick_found;
    // Reset gates the write path directly so a mid-burst reset never leaks an ack.
    assign write    = any_cand && !full && wrst_n;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
            assign req_words[gi] = req_data[gi*DSIZE +: DSIZE];
            assign ack[gi]       = write && (sel == IW'(gi));
        end
    endgenerate

    assign w_en    = write;
    assign data_in = (wrst_n && any_cand) ? req_words[sel] : '0;
    assign busy    = wrst_n && (state_reg == OWN);
    assign owner   = owner_reg;

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            state_reg      <= IDLE;
            owner_reg      <= '0;
            burst_cnt_reg  <= '0;
            last_grant_reg <= IW'(NUM_REQ - 1);
        end else if (write) begin
            if (cont) begin
                burst_cnt_reg <= burst_cnt_reg + BW'(1);
            end else begin
                state_reg      <= OWN;
                owner_reg      <= sel;
                last_grant_reg <= sel;
                burst_cnt_reg  <= BW'(1);
            end
        end else if (!full && !(|req)) begin
            // Full alone stalls with everything held; only an empty request set idles.
            state_reg     <= IDLE;
            burst_cnt_reg <= '0;
        end
    end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Self-checking bench: directed table, multi-cycle corner sequences, then random traffic vs a model.
module tb_fifo_write_arbiter;

    localparam int DSIZE     = 8;
    localparam int NUM_REQ   = 4;
    localparam int BURST_MAX = 4;

    logic                     wclk = 1'b0;
    logic                     wrst_n = 1'b1;
    logic [NUM_REQ-1:0]       req = '0;
    logic [NUM_REQ*DSIZE-1:0] req_data = '0;
    logic [NUM_REQ-1:0]       ack;
    logic                     full = 1'b0;
    logic                     w_en;
    logic [DSIZE-1:0]         data_in;
    logic                     busy;
    logic [1:0]               owner;

    int n_checks = 0;
    int n_errors = 0;

    fifo_write_arbiter #(
        .DSIZE     (DSIZE),
        .NUM_REQ   (NUM_REQ),
        .BURST_MAX (BURST_MAX)
    ) dut (
        .wclk     (wclk),
        .wrst_n   (wrst_n),
        .req      (req),
        .req_data (req_data),
        .ack      (ack),
        .full     (full),
        .w_en     (w_en),
        .data_in  (data_in),
        .busy     (busy),
        .owner    (owner)
    );

    always #5 wclk = ~wclk;

    typedef struct {
        logic [3:0] req;
        logic       full;
        logic [3:0] exp_ack;
        logic       exp_busy;
        logic [1:0] exp_owner;
    } vec_t;

    vec_t tbl[$];

    // Behavioural model state: ownership described as plain integers.
    int m_busy, m_owner, m_cnt, m_last;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] slice_of(input logic [31:0] d, input int i);
        return d[i*8 +: 8];
    endfunction

    function automatic int onehot_idx(input logic [3:0] v);
        for (int i = 0; i < NUM_REQ; i++) begin
            if (v[i]) return i;
        end
        return 0;
    endfunction

    task automatic addv(input logic [3:0] r, input logic f, input logic [3:0] a,
                        input logic b, input logic [1:0] o);
        vec_t v;
        v.req = r; v.full = f; v.exp_ack = a; v.exp_busy = b; v.exp_owner = o;
        tbl.push_back(v);
    endtask

    // Called at posedge+1: drive, compare combinational outputs at negedge, then owner after the edge.
    task automatic step(input string name, input logic [3:0] r, input logic f,
                        input logic [3:0] e_ack, input logic e_busy, input logic [1:0] e_owner);
        req  = r;
        full = f;
        if (!f) req_data = $urandom;
        @(negedge wclk);
        chk({name, ".ack"}, 32'(ack), 32'(e_ack));
        chk({name, ".w_en"}, 32'(w_en), 32'(|e_ack));
        chk({name, ".busy"}, 32'(busy), 32'(e_busy));
        if (e_ack != 4'b0000) begin
            chk({name, ".data"}, 32'(data_in), 32'(slice_of(req_data, onehot_idx(e_ack))));
        end
        $display("%s req=%b full=%b ack=%b w_en=%b data=%h busy=%b", name, r, f, ack, w_en, data_in, busy);
        @(posedge wclk);
        #1;
        chk({name, ".owner"}, 32'(owner), 32'(e_owner));
    endtask

    task automatic pulse_reset();
        wrst_n = 1'b0;
        req    = '0;
        full   = 1'b0;
        @(posedge wclk);
        #1;
        wrst_n = 1'b1;
    endtask

    function automatic int m_pick(input logic [3:0] r, output bit c);
        c = (m_busy != 0) && r[m_owner] && (m_cnt < BURST_MAX);
        if (c) return m_owner;
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (r[(m_last + k) % NUM_REQ]) return (m_last + k) % NUM_REQ;
        end
        return -1;
    endfunction

    initial begin
        // Reset held with every requester asking: nothing may be written.
        #1;
        wrst_n   = 1'b0;
        req      = 4'b1111;
        req_data = $urandom;
        #11;
        chk("rst.w_en", 32'(w_en), 32'd0);
        chk("rst.ack", 32'(ack), 32'd0);
        chk("rst.busy", 32'(busy), 32'd0);
        chk("rst.owner", 32'(owner), 32'd0);
        chk("rst.data", 32'(data_in), 32'd0);
        @(posedge wclk);
        @(posedge wclk);
        #1;
        wrst_n = 1'b1;

        // Bursts of four, full stall, owner drop, idle, then a lone requester re-granted.
        addv(4'b1111, 0, 4'b0001, 0, 2'd0);
        addv(4'b1111, 0, 4'b0001, 1, 2'd0);
        addv(4'b1111, 0, 4'b0001, 1, 2'd0);
        addv(4'b1111, 0, 4'b0001, 1, 2'd0);
        addv(4'b1111, 0, 4'b0010, 1, 2'd1);
        addv(4'b1111, 0, 4'b0010, 1, 2'd1);
        addv(4'b1111, 1, 4'b0000, 1, 2'd1);
        addv(4'b1111, 1, 4'b0000, 1, 2'd1);
        addv(4'b1111, 1, 4'b0000, 1, 2'd1);
        addv(4'b1111, 0, 4'b0010, 1, 2'd1);
        addv(4'b1111, 0, 4'b0010, 1, 2'd1);
        addv(4'b1111, 0, 4'b0100, 1, 2'd2);
        addv(4'b1001, 0, 4'b1000, 1, 2'd3);
        addv(4'b0001, 0, 4'b0001, 1, 2'd0);
        addv(4'b0001, 0, 4'b0001, 1, 2'd0);
        addv(4'b0000, 0, 4'b0000, 1, 2'd0);
        addv(4'b0100, 0, 4'b0100, 0, 2'd2);
        addv(4'b0100, 0, 4'b0100, 1, 2'd2);
        addv(4'b0100, 0, 4'b0100, 1, 2'd2);
        addv(4'b0100, 0, 4'b0100, 1, 2'd2);
        addv(4'b0100, 0, 4'b0100, 1, 2'd2);
        addv(4'b0100, 0, 4'b0100, 1, 2'd2);
        for (int i = 0; i < tbl.size(); i++) begin
            step($sformatf("tbl%0d", i), tbl[i].req, tbl[i].full, tbl[i].exp_ack,
                 tbl[i].exp_busy, tbl[i].exp_owner);
        end

        // Owner 0 drops after two words; requester 3 takes over with no bubble.
        pulse_reset();
        step("drop0", 4'b0001, 0, 4'b0001, 0, 2'd0);
        step("drop1", 4'b0001, 0, 4'b0001, 1, 2'd0);
        step("drop2", 4'b1000, 0, 4'b1000, 1, 2'd3);

        // Reset pulse between edges mid-burst, then requester 0 wins first.
        pulse_reset();
        step("mid0", 4'b0100, 0, 4'b0100, 0, 2'd2);
        step("mid1", 4'b0100, 0, 4'b0100, 1, 2'd2);
        step("mid2", 4'b0100, 0, 4'b0100, 1, 2'd2);
        wrst_n = 1'b0;
        #1;
        chk("mid.w_en", 32'(w_en), 32'd0);
        chk("mid.ack", 32'(ack), 32'd0);
        chk("mid.busy", 32'(busy), 32'd0);
        chk("mid.owner", 32'(owner), 32'd0);
        #1;
        wrst_n = 1'b1;
        step("mid3", 4'b1111, 0, 4'b0001, 0, 2'd0);

        // Random traffic: requests held until acked, random full.
        pulse_reset();
        m_busy = 0; m_owner = 0; m_cnt = 0; m_last = NUM_REQ - 1;
        req = '0;
        for (int cyc = 0; cyc < 500; cyc++) begin : rnd_loop
            int         s;
            bit         c;
            bit         wr;
            logic [3:0] e_ack;
            logic [7:0] e_data;
            full   = ($urandom_range(0, 3) == 0);
            s      = m_pick(req, c);
            wr     = (s >= 0) && !full;
            e_ack  = wr ? 4'(1 << s) : 4'b0000;
            e_data = (s >= 0) ? slice_of(req_data, s) : 8'h00;
            @(negedge wclk);
            chk("rnd.ack", 32'(ack), 32'(e_ack));
            chk("rnd.w_en", 32'(w_en), 32'(wr));
            chk("rnd.data", 32'(data_in), 32'(e_data));
            chk("rnd.busy", 32'(busy), 32'(m_busy != 0));
            if (wr) $display("rnd%0d write from %0d data=%h", cyc, s, data_in);
            @(posedge wclk);
            #1;
            if (wr) begin
                if (c) m_cnt++;
                else begin
                    m_owner = s; m_last = s; m_cnt = 1; m_busy = 1;
                end
            end else if (!full && req == 4'b0000) begin
                m_busy = 0; m_cnt = 0;
            end
            chk("rnd.owner", 32'(owner), 32'(m_owner));
            for (int i = 0; i < NUM_REQ; i++) begin
                if (e_ack[i]) begin
                    req[i] = ($urandom_range(0, 1) == 1);
                    req_data[i*8 +: 8] = 8'($urandom);
                end else if (!req[i] && $urandom_range(0, 2) == 0) begin
                    req[i] = 1'b1;
                    req_data[i*8 +: 8] = 8'($urandom);
                end
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
